// File: rtl/slave_bus_pkg.sv
// Shared definitions for the serial burst slave: default widths and FSM state encoding.
package slave_bus_pkg;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned BURST_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel shifter. word_o and done_o already include the bit being
// sampled this cycle, so the parent can latch a complete word on the edge of its last bit.
module serial_deser #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         bit_i,
  output logic [W-1:0] word_o,
  output logic         done_o
);

  localparam int unsigned   CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift_s;

  assign shift_s = en_i & ~clr_i;
  assign word_o  = shift_s ? {bit_i, shreg_q[W-1:1]} : shreg_q;
  assign done_o  = shift_s & (cnt_q == LAST);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_s) begin
      shreg_d = word_o;
      cnt_d   = done_o ? '0 : cnt_q + CW'(1);
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_burst_rx.sv
// Serial burst slave: receives a serial address (and write data) after a valid/ready
// handshake, then serves a burst of N+1 words with auto-incrementing address.
module slave_burst_rx
  import slave_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_addr,
  input  logic               rx_data,
  input  logic               master_valid,
  input  logic               master_ready,
  input  logic               write_en,
  input  logic               read_en,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [BURST_W-1:0] burst_counter,
  output logic               slave_ready,
  output logic               wr_strobe,
  output logic               read_enable,
  output logic               rx_done,
  output logic               err
);

  state_e               state_q;
  logic                 wr_q, data_got_q;
  logic [BURST_W-1:0]   burst_q, burst_counter_q;
  logic [ADDR_W-1:0]    addr_out_q;
  logic [DATA_W-1:0]    data_out_q;
  logic                 slave_ready_q, wr_strobe_q, read_enable_q, rx_done_q, err_q;

  logic                 hs_s, addr_en_s, data_en_s, addr_done_s, data_done_s;
  logic [ADDR_W-1:0]    addr_word_s;
  logic [DATA_W-1:0]    data_word_s;

  assign hs_s      = slave_ready_q & master_valid & (write_en ^ read_en);
  assign addr_en_s = (state_q == ADDR);
  // The data lane runs during ADDR only for writes and only until the first word is in.
  assign data_en_s = ((state_q == ADDR) & wr_q & ~data_got_q) | (state_q == DATA);

  serial_deser #(.W(ADDR_W)) u_addr_deser (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (addr_en_s),
    .clr_i  (hs_s),
    .bit_i  (rx_addr),
    .word_o (addr_word_s),
    .done_o (addr_done_s)
  );

  serial_deser #(.W(DATA_W)) u_data_deser (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (data_en_s),
    .clr_i  (hs_s),
    .bit_i  (rx_data),
    .word_o (data_word_s),
    .done_o (data_done_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      wr_q            <= 1'b0;
      data_got_q      <= 1'b0;
      burst_q         <= '0;
      burst_counter_q <= '0;
      addr_out_q      <= '0;
      data_out_q      <= '0;
      slave_ready_q   <= 1'b1;
      wr_strobe_q     <= 1'b0;
      read_enable_q   <= 1'b0;
      rx_done_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rx_done_q   <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs_s) begin
            wr_q            <= write_en;
            burst_q         <= burst;
            burst_counter_q <= '0;
            data_got_q      <= 1'b0;
            slave_ready_q   <= 1'b0;
            state_q         <= ADDR;
          end else if (master_valid && write_en && read_en) begin
            err_q <= 1'b1;
          end
        end
        ADDR: begin
          if (data_done_s) begin
            data_got_q <= 1'b1;
          end
          if (addr_done_s) begin
            addr_out_q <= addr_word_s;
            if (wr_q) begin
              data_out_q      <= data_word_s;
              wr_strobe_q     <= 1'b1;
              burst_counter_q <= burst_counter_q + BURST_W'(1);
              state_q         <= (burst_q == '0) ? DONE : DATA;
            end else begin
              read_enable_q <= 1'b1;
              state_q       <= RD_WAIT;
            end
          end
        end
        DATA: begin
          if (data_done_s) begin
            data_out_q      <= data_word_s;
            addr_out_q      <= addr_out_q + ADDR_W'(1);
            wr_strobe_q     <= 1'b1;
            burst_counter_q <= burst_counter_q + BURST_W'(1);
            if (burst_counter_q == burst_q) begin
              state_q <= DONE;
            end
          end
        end
        RD_WAIT: begin
          // The counter still holds the words served before this one.
          if (master_ready) begin
            burst_counter_q <= burst_counter_q + BURST_W'(1);
            if (burst_counter_q == burst_q) begin
              read_enable_q <= 1'b0;
              state_q       <= DONE;
            end else begin
              addr_out_q <= addr_out_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          rx_done_q     <= 1'b1;
          slave_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: begin
          read_enable_q <= 1'b0;
          slave_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign addr_out      = addr_out_q;
  assign data_out      = data_out_q;
  assign burst_counter = burst_counter_q;
  assign slave_ready   = slave_ready_q;
  assign wr_strobe     = wr_strobe_q;
  assign read_enable   = read_enable_q;
  assign rx_done       = rx_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_slave_burst_rx.sv
// Self-checking bench for slave_burst_rx: directed transfers with a write scoreboard.
module tb_slave_burst_rx;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 12;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               rx_addr = 1'b0, rx_data = 1'b0;
  logic               master_valid = 1'b0, master_ready = 1'b0;
  logic               write_en = 1'b0, read_en = 1'b0;
  logic [BURST_W-1:0] burst = '0;
  logic [ADDR_W-1:0]  addr_out;
  logic [DATA_W-1:0]  data_out;
  logic [BURST_W-1:0] burst_counter;
  logic               slave_ready, wr_strobe, read_enable, rx_done, err;

  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [DATA_W-1:0]  d;
    logic [BURST_W-1:0] c;
  } wr_exp_t;

  wr_exp_t           sb[$];
  wr_exp_t           mon_e;
  logic [DATA_W-1:0] wq[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                n_vec = 0, n_miscompare = 0;
  bit                noise = 1'b0;

  always #5 clk = ~clk;

  slave_burst_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset), .rx_addr(rx_addr), .rx_data(rx_data),
    .master_valid(master_valid), .master_ready(master_ready),
    .write_en(write_en), .read_en(read_en), .burst(burst),
    .addr_out(addr_out), .data_out(data_out), .burst_counter(burst_counter),
    .slave_ready(slave_ready), .wr_strobe(wr_strobe), .read_enable(read_enable),
    .rx_done(rx_done), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && wr_strobe) begin
      if (sb.size() == 0) begin
        check_val("wr_unexpected", {31'd0, wr_strobe}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("wr_addr", {20'd0, addr_out}, {20'd0, mon_e.a});
        check_val("wr_data", {24'd0, data_out}, {24'd0, mon_e.d});
        check_val("wr_cnt", {20'd0, burst_counter}, {20'd0, mon_e.c});
      end
    end
  end

  task automatic handshake(input logic we, input logic re, input logic [BURST_W-1:0] n);
    int t = 0;
    while (slave_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    check_val("hs_ready", {31'd0, slave_ready}, 32'd1);
    master_valid = 1'b1; write_en = we; read_en = re; burst = n;
    step();
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0; burst = BURST_W'($urandom);
    check_val("hs_taken", {31'd0, slave_ready}, 32'd0);
  endtask

  task automatic shift_addr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic we);
    wr_exp_t e;
    for (int i = 0; i < ADDR_W; i++) begin
      rx_addr = a[i];
      rx_data = (we && i < DATA_W) ? d[i] : 1'($urandom);
      if (noise) begin
        master_valid = 1'($urandom); write_en = 1'($urandom);
        read_en = 1'($urandom); burst = BURST_W'($urandom);
      end
      if (we && i == ADDR_W - 1) begin
        e.a = a; e.d = d; e.c = BURST_W'(1);
        sb.push_back(e);
      end
      step();
    end
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    if (we) check_val("wr_strobe_addr", {31'd0, wr_strobe}, 32'd1);
    else begin
      check_val("rd_en_on", {31'd0, read_enable}, 32'd1);
      check_val("rd_addr", {20'd0, addr_out}, {20'd0, a});
    end
  endtask

  task automatic shift_word(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] ea,
                            input logic [BURST_W-1:0] c, input int nbits);
    wr_exp_t e;
    for (int i = 0; i < nbits; i++) begin
      rx_data = d[i];
      if (i == DATA_W - 1) begin
        e.a = ea; e.d = d; e.c = c;
        sb.push_back(e);
      end
      step();
    end
    if (nbits == DATA_W) check_val("wr_strobe_data", {31'd0, wr_strobe}, 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w[$]);
    logic [ADDR_W-1:0]  ea;
    logic [BURST_W-1:0] n;
    n = BURST_W'(w.size() - 1);
    handshake(1'b1, 1'b0, n);
    shift_addr(a, w[0], 1'b1);
    ea = a;
    for (int k = 1; k < w.size(); k++) begin
      ea = ea + ADDR_W'(1);
      shift_word(w[k], ea, BURST_W'(k + 1), DATA_W);
    end
    check_val("done_early", {31'd0, rx_done}, 32'd0);
    step();
    check_val("rx_done", {31'd0, rx_done}, 32'd1);
    check_val("ready_back", {31'd0, slave_ready}, 32'd1);
    check_val("cnt_final", {20'd0, burst_counter}, 32'(w.size()));
    step();
    check_val("done_pulse", {31'd0, rx_done}, 32'd0);
    check_val("addr_hold", {20'd0, addr_out}, {20'd0, ea});
    exp_addr = ea;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int n, input int w);
    logic [ADDR_W-1:0] ea;
    handshake(1'b0, 1'b1, BURST_W'(n));
    shift_addr(a, '0, 1'b0);
    ea = a;
    for (int k = 0; k <= n; k++) begin
      repeat (w) begin
        step();
        check_val("rd_en_wait", {31'd0, read_enable}, 32'd1);
      end
      master_ready = 1'b1;
      step();
      master_ready = 1'b0;
      check_val("rd_cnt", {20'd0, burst_counter}, 32'(k + 1));
      if (k < n) begin
        ea = ea + ADDR_W'(1);
        check_val("rd_en_hold", {31'd0, read_enable}, 32'd1);
        check_val("rd_addr_adv", {20'd0, addr_out}, {20'd0, ea});
      end else begin
        check_val("rd_en_off", {31'd0, read_enable}, 32'd0);
      end
    end
    check_val("rd_done_early", {31'd0, rx_done}, 32'd0);
    step();
    check_val("rd_done", {31'd0, rx_done}, 32'd1);
    check_val("rd_ready_back", {31'd0, slave_ready}, 32'd1);
    exp_addr = ea;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_addr"}, {20'd0, addr_out}, 32'd0);
    check_val({tag, "_data"}, {24'd0, data_out}, 32'd0);
    check_val({tag, "_cnt"}, {20'd0, burst_counter}, 32'd0);
    check_val({tag, "_flags"}, {28'd0, wr_strobe, read_enable, rx_done, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    step();
    check_val("rst_ready", {31'd0, slave_ready}, 32'd1);

    wq = {8'h55};
    do_write(12'h2AA, wq);
    wq = {8'h11, 8'h22, 8'h33};
    do_write(12'hFFF, wq);
    do_read(12'h123, 0, 3);
    do_read(12'h0FE, 2, 1);

    // both enables: err pulse, no state change; no enables: silently ignored
    master_valid = 1'b1; write_en = 1'b1; read_en = 1'b1;
    step();
    check_val("ill_err", {31'd0, err}, 32'd1);
    check_val("ill_ready", {31'd0, slave_ready}, 32'd1);
    check_val("ill_addr", {20'd0, addr_out}, {20'd0, exp_addr});
    write_en = 1'b0; read_en = 1'b0;
    step();
    check_val("none_err", {31'd0, err}, 32'd0);
    check_val("none_ready", {31'd0, slave_ready}, 32'd1);
    master_valid = 1'b0;
    step();
    check_val("ill_cnt", {20'd0, burst_counter}, 32'd3);

    noise = 1'b1;
    wq = {8'hC3};
    do_write(12'h5A3, wq);
    noise = 1'b0;

    // reset during the second word of a 4-word burst
    handshake(1'b1, 1'b0, BURST_W'(3));
    shift_addr(12'h3C5, 8'h9E, 1'b1);
    shift_word(8'h71, 12'h3C6, BURST_W'(2), 4);
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    step();
    check_val("mid_rst_ready", {31'd0, slave_ready}, 32'd1);
    repeat (10) step();
    check_reset_outputs("post_rst");

    wq = {8'hA5, 8'h5A};
    do_write(12'h0F0, wq);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/slave_burst_rx.md
SLAVE_BURST_RX -- requirements
Module: slave_burst_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width in bits (serial address frame length).
REQ-002 SHALL have parameter DATA_W, default 8, data word width in bits; legal only when DATA_W <= ADDR_W.
REQ-003 SHALL have parameter BURST_W, default 12, width of burst length field and burst counter.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx_addr, input, 1, serial address lane, LSB first.
REQ-007 SHALL have port rx_data, input, 1, serial data lane, LSB first.
REQ-008 SHALL have ports master_valid and master_ready, inputs, 1 each: request valid, and master able to take read data.
REQ-009 SHALL have ports write_en and read_en, inputs, 1 each, transfer direction; sampled at the handshake edge.
REQ-010 SHALL have port burst, input, BURST_W, burst length N meaning N+1 words; sampled at the handshake edge.
REQ-011 SHALL have outputs addr_out (ADDR_W), data_out (DATA_W), burst_counter (BURST_W): current word address, word, and words completed.
REQ-012 SHALL have 1-bit outputs slave_ready, wr_strobe, read_enable, rx_done, err.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, RD_WAIT, DONE.
REQ-014 SHALL assert slave_ready only in IDLE.
REQ-015 SHALL accept a request at the edge where slave_ready, master_valid and exactly one of write_en/read_en are 1, capture direction and burst, clear burst_counter, and go to ADDR.
REQ-016 SHALL, if master_valid with both enables 1, stay in IDLE and pulse err 1 cycle; with neither enable, ignore it without err.
REQ-017 SHALL in ADDR sample rx_addr bit i on the i-th edge after the handshake (i = 0..ADDR_W-1) and, for writes, rx_data bit i for i < DATA_W.
REQ-018 SHALL on write ADDR completion update addr_out and data_out, pulse wr_strobe 1 cycle, increment burst_counter, then go to DATA if words remain, else DONE.
REQ-019 SHALL in DATA shift DATA_W bits per word, then update data_out, increment addr_out modulo 2^ADDR_W, pulse wr_strobe and increment burst_counter.
REQ-020 SHALL on read ADDR completion update addr_out, go to RD_WAIT, and hold read_enable high until the cycle master_ready is 1 (that cycle included).
REQ-021 SHALL in RD_WAIT, for burst N > 0, advance addr_out by one and increment burst_counter on each master_ready cycle, staying in RD_WAIT until N+1 words are served.
REQ-022 SHALL pulse rx_done 1 cycle in DONE, then return to IDLE (slave_ready high the following cycle).
REQ-023 SHALL ignore master_valid, enables and burst outside IDLE.
REQ-024 SHALL hold addr_out, data_out and burst_counter stable between updates and until the next accepted request.

Reset
REQ-025 SHALL on reset low immediately force IDLE, addr_out=0, data_out=0, burst_counter=0, wr_strobe=read_enable=rx_done=err=0, slave_ready=1 after release, including mid-burst.
REQ-026 SHALL discard any partially shifted word on reset; no wr_strobe for it.

Structure
REQ-027 SHALL place the FSM state enumeration and default width constants in shared package slave_bus_pkg.
REQ-028 SHALL implement serial-to-parallel shifting in one sub-module serial_deser (parametrised width, shift enable, clear, done flag), instantiated once per lane.

Verification
REQ-029 SHALL cover single write: addr 0x2AA, data 0x55, burst 0 -> wr_strobe at edge 12 after handshake, addr_out=0x2AA, data_out=0x55, rx_done next cycle.
REQ-030 SHALL cover wrap burst: write addr 0xFFF, burst 2, data 0x11/0x22/0x33 -> three wr_strobes with addr_out 0xFFF, 0x000, 0x001, burst_counter ending at 3.
REQ-031 SHALL cover read: addr 0x123, burst 0, master_ready held low 3 cycles -> read_enable high 4 cycles, rx_done after master_ready.
REQ-032 SHALL cover illegal request: write_en=read_en=1 with valid -> err pulse, slave_ready stays 1, no state change.
REQ-033 SHALL cover reset mid-burst: reset low during word 2 of burst 3 -> all outputs at reset values, next request accepted normally.
REQ-034 SHALL cover ignored mid-transfer valid: master_valid toggled during ADDR -> no effect on addr_out or timing.
